// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: stage IRs and pipeline control in, forwarding/interlock results out
interface fwd_hazard_if #(parameter int CNT_W = 16);
    logic [31:0] of_ir, ex_ir, ma_ir, rw_ir;
    logic pipe_adv, branch_taken;
    logic stall_of, of_fwd_a, of_fwd_b, ma_fwd_st;
    logic [1:0] ex_sel_a, ex_sel_b, ex_sel_st;
    logic [CNT_W-1:0] stall_cnt, fwd_cnt;
    modport master (
        output of_ir, ex_ir, ma_ir, rw_ir, pipe_adv, branch_taken,
        input stall_of, of_fwd_a, of_fwd_b, ma_fwd_st, ex_sel_a, ex_sel_b, ex_sel_st, stall_cnt, fwd_cnt
    );
    modport slave (
        input of_ir, ex_ir, ma_ir, rw_ir, pipe_adv, branch_taken,
        output stall_of, of_fwd_a, of_fwd_b, ma_fwd_st, ex_sel_a, ex_sel_b, ex_sel_st, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding, load-use interlock and perf counters for the 5-stage pipe
module fwd_hazard_unit #(
    parameter int REG_W = 4,
    parameter int RA_IDX = 15,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    fwd_hazard_if.slave hz
);
    localparam logic [0:0] IDLE = 1'b0, STALL = 1'b1;
    localparam logic [4:0] OP_LD = 5'd14, OP_ST = 5'd15, OP_CALL = 5'd19, OP_RET = 5'd20;
    typedef logic [REG_W-1:0] idx_t;
    function automatic logic is_wr(input logic [31:0] ir);
        return !(ir[31:27] inside {5'd5, 5'd13, 5'd15, 5'd16, 5'd17, 5'd18, 5'd20});
    endfunction
    function automatic idx_t dst(input logic [31:0] ir);
        return ir[31:27] == OP_CALL ? idx_t'(RA_IDX) : ir[22 +: REG_W];
    endfunction
    function automatic logic hit(input logic [31:0] p, input logic rd, input idx_t idx);
        return rd && is_wr(p) && dst(p) == idx;
    endfunction
    function automatic logic [1:0] sel(input logic [31:0] ex, input logic [31:0] ma, input logic rd, input idx_t idx);
        return hit(ex, rd, idx) ? 2'b01 : hit(ma, rd, idx) ? 2'b10 : 2'b00;
    endfunction
    logic [0:0] state;
    logic [1:0] sel_a, sel_b, sel_st, nxt_a, nxt_b, nxt_st;
    logic [CNT_W-1:0] stall_cnt, fwd_cnt;
    logic r1, r2, rs, ms, fa, fb, fs, flush, ld_use, stall, fwd_any;
    idx_t i1, i2, is, ma_is;
    logic [4:0] op;
    always_comb begin
        op = hz.of_ir[31:27];
        r1 = (op <= 5'd12 && !(op inside {5'd8, 5'd9})) || op inside {OP_LD, OP_ST, OP_RET};
        i1 = op == OP_RET ? idx_t'(RA_IDX) : hz.of_ir[18 +: REG_W];
        r2 = op <= 5'd12 && !hz.of_ir[26];
        i2 = hz.of_ir[14 +: REG_W];
        rs = op == OP_ST;
        is = hz.of_ir[22 +: REG_W];
        ms = hz.ma_ir[31:27] == OP_ST;
        ma_is = hz.ma_ir[22 +: REG_W];
        fa = hit(hz.rw_ir, r1, i1);
        fb = hit(hz.rw_ir, r2, i2);
        fs = hit(hz.rw_ir, ms, ma_is);
        flush = hz.pipe_adv && hz.branch_taken;
        ld_use = hz.ex_ir[31:27] == OP_LD && (hit(hz.ex_ir, r1, i1) || hit(hz.ex_ir, r2, i2) || hit(hz.ex_ir, rs, is));
        stall = state == IDLE && ld_use && !flush;
        nxt_a = (flush || stall) ? 2'b00 : sel(hz.ex_ir, hz.ma_ir, r1, i1);
        nxt_b = (flush || stall) ? 2'b00 : sel(hz.ex_ir, hz.ma_ir, r2, i2);
        nxt_st = (flush || stall) ? 2'b00 : sel(hz.ex_ir, hz.ma_ir, rs, is);
        fwd_any = fa || fb || fs || |{nxt_a, nxt_b, nxt_st};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            {sel_a, sel_b, sel_st} <= '0;
            stall_cnt <= '0;
            fwd_cnt <= '0;
        end else if (hz.pipe_adv) begin
            state <= stall ? STALL : IDLE;
            sel_a <= nxt_a;
            sel_b <= nxt_b;
            sel_st <= nxt_st;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (fwd_any && !(&fwd_cnt)) fwd_cnt <= fwd_cnt + 1'b1;
        end
    end
    assign hz.stall_of = stall;
    assign hz.of_fwd_a = fa;
    assign hz.of_fwd_b = fb;
    assign hz.ma_fwd_st = fs;
    assign hz.ex_sel_a = sel_a;
    assign hz.ex_sel_b = sel_b;
    assign hz.ex_sel_st = sel_st;
    assign hz.stall_cnt = stall_cnt;
    assign hz.fwd_cnt = fwd_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors with a queued scoreboard; a CNT_W=2 twin checks saturation
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    fwd_hazard_if #(.CNT_W(16)) hz ();
    fwd_hazard_if #(.CNT_W(2)) hz2 ();
    assign hz2.of_ir = hz.of_ir;
    assign hz2.ex_ir = hz.ex_ir;
    assign hz2.ma_ir = hz.ma_ir;
    assign hz2.rw_ir = hz.rw_ir;
    assign hz2.pipe_adv = hz.pipe_adv;
    assign hz2.branch_taken = hz.branch_taken;
    fwd_hazard_unit #(.REG_W(4), .RA_IDX(15), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));
    fwd_hazard_unit #(.REG_W(4), .RA_IDX(15), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .hz(hz2.slave));
    typedef struct {
        int id;
        logic [9:0] o;
        logic [15:0] sc, fc;
    } exp_t;
    exp_t q[$];
    function automatic logic [31:0] ir(input int op, input bit i, input int d, input int s1, input int s2);
        logic [4:0] o5 = 5'(op);
        logic [3:0] d4 = 4'(d), a4 = 4'(s1), b4 = 4'(s2);
        return {o5, i, d4, a4, b4, 14'b0};
    endfunction
    function automatic logic [1:0] sat2(input logic [15:0] v);
        return v > 16'd3 ? 2'd3 : v[1:0];
    endfunction
    int vid = 0;
    task automatic v(input logic r, input logic [31:0] of, ex, ma, rw, input logic adv, bt,
                     input logic [9:0] o, input int sc, input int fc);
        @(negedge clk);
        rst_n = r;
        hz.of_ir = of;
        hz.ex_ir = ex;
        hz.ma_ir = ma;
        hz.rw_ir = rw;
        hz.pipe_adv = adv;
        hz.branch_taken = bt;
        q.push_back('{vid, o, 16'(sc), 16'(fc)});
        vid++;
    endtask
    initial begin
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                act = {hz.stall_of, hz.of_fwd_a, hz.of_fwd_b, hz.ma_fwd_st, hz.ex_sel_a, hz.ex_sel_b, hz.ex_sel_st};
                total++;
                if (act !== e.o) begin
                    bad++;
                    $display("FAIL v%0d outs got=%b want=%b", e.id, act, e.o);
                end
                total++;
                if ({hz.stall_cnt, hz.fwd_cnt} !== {e.sc, e.fc}) begin
                    bad++;
                    $display("FAIL v%0d cnt16 got=%0d/%0d want=%0d/%0d", e.id, hz.stall_cnt, hz.fwd_cnt, e.sc, e.fc);
                end
                total++;
                if ({hz2.stall_cnt, hz2.fwd_cnt} !== {sat2(e.sc), sat2(e.fc)}) begin
                    bad++;
                    $display("FAIL v%0d cnt2 got=%0d/%0d want=%0d/%0d", e.id, hz2.stall_cnt, hz2.fwd_cnt, sat2(e.sc), sat2(e.fc));
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] n, sub4, add1, add3, ld1, ret, call, st5, add5, addi, add1b, st2, add2;
        n = ir(13, 0, 0, 0, 0);
        sub4 = ir(1, 0, 4, 1, 5);
        add1 = ir(0, 0, 1, 2, 3);
        add3 = ir(0, 0, 3, 1, 1);
        ld1 = ir(14, 0, 1, 2, 0);
        ret = ir(20, 0, 0, 0, 0);
        call = ir(19, 0, 0, 0, 0);
        st5 = ir(15, 0, 5, 6, 0);
        add5 = ir(0, 0, 5, 1, 2);
        addi = ir(0, 1, 7, 2, 1);
        add1b = ir(0, 0, 1, 3, 4);
        st2 = ir(15, 0, 2, 3, 0);
        add2 = ir(0, 0, 2, 0, 0);
        hz.of_ir = n;
        hz.ex_ir = n;
        hz.ma_ir = n;
        hz.rw_ir = n;
        hz.pipe_adv = 1'b1;
        hz.branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        v(0, n, n, n, n, 1, 0, 10'b0000_00_00_00, 0, 0);
        v(1, sub4, add1, n, n, 1, 0, 10'b0000_00_00_00, 0, 0);
        v(1, n, sub4, add1, n, 1, 0, 10'b0000_01_00_00, 0, 1);
        v(1, add3, ld1, n, n, 1, 0, 10'b1000_00_00_00, 0, 1);
        v(1, add3, n, ld1, n, 1, 0, 10'b0000_00_00_00, 1, 1);
        v(1, n, add3, n, ld1, 1, 0, 10'b0000_10_10_00, 1, 2);
        v(1, ret, n, n, call, 1, 0, 10'b0100_00_00_00, 1, 2);
        v(1, n, n, st5, add5, 1, 0, 10'b0001_00_00_00, 1, 3);
        v(1, addi, add1b, n, n, 1, 0, 10'b0000_00_00_00, 1, 4);
        v(1, st2, n, add2, n, 1, 0, 10'b0000_00_00_00, 1, 4);
        v(1, n, n, n, n, 1, 0, 10'b0000_00_00_10, 1, 5);
        v(1, add3, ld1, n, n, 1, 1, 10'b0000_00_00_00, 1, 5);
        v(1, add3, ld1, n, n, 1, 0, 10'b1000_00_00_00, 1, 5);
        repeat (5) v(1, add3, ld1, n, n, 0, 0, 10'b0000_00_00_00, 2, 5);
        v(1, add3, n, ld1, n, 1, 0, 10'b0000_00_00_00, 2, 5);
        v(1, add3, n, ld1, n, 1, 0, 10'b0000_10_10_00, 2, 6);
        v(0, add3, n, ld1, n, 1, 0, 10'b0000_10_10_00, 2, 7);
        v(1, n, n, n, n, 1, 0, 10'b0000_00_00_00, 0, 0);
        @(negedge clk);
        #4;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
